// File: rtl/board_controller.sv
// board_controller: tic-tac-toe game sequencer for a human player versus a strategy stage.
// Registers both boards, validates moves, detects wins/draws and falls back to a safe computer move.
module board_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [8:0] human_move,
    input  logic       human_valid,
    input  logic [8:0] comp_move,
    output logic [8:0] computer,
    output logic [8:0] human,
    output logic       human_ready,
    output logic       illegal,
    output logic       fallback,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [3:0] move_count
);
    typedef enum logic [2:0] {IDLE, HUMAN_TURN, H_CHECK, COMP_TURN, C_CHECK, DONE} state_t;
    state_t     state_q, state_d;
    logic [8:0] comp_q, comp_d, hum_q, hum_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] win_q, win_d;
    logic       ill_q, ill_d, fb_q, fb_d;
    logic [8:0] occ, free, low_free;
    function automatic logic has_line(input logic [8:0] b);
        return (&b[8:6]) | (&b[5:3]) | (&b[2:0]) |
               (b[8] & b[5] & b[2]) | (b[7] & b[4] & b[1]) | (b[6] & b[3] & b[0]) |
               (b[8] & b[4] & b[0]) | (b[6] & b[4] & b[2]);
    endfunction
    function automatic logic one_hot(input logic [8:0] m);
        return (m != 9'd0) && ((m & (m - 9'd1)) == 9'd0);
    endfunction
    assign occ      = comp_q | hum_q;
    assign free     = ~occ;
    // Isolates the lowest-index empty cell; never zero in COMP_TURN since move_count < 9 there.
    assign low_free = free & (~free + 9'd1);
    always_comb begin
        state_d = state_q;
        comp_d  = comp_q;
        hum_d   = hum_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        ill_d   = 1'b0;
        fb_d    = 1'b0;
        case (state_q)
            IDLE: ;
            HUMAN_TURN:
                if (human_valid) begin
                    if (one_hot(human_move) && (human_move & occ) == 9'd0) begin
                        hum_d   = hum_q | human_move;
                        cnt_d   = cnt_q + 4'd1;
                        state_d = H_CHECK;
                    end else begin
                        ill_d = 1'b1;
                    end
                end
            H_CHECK: begin
                state_d = (has_line(hum_q) || cnt_q == 4'd9) ? DONE : COMP_TURN;
                win_d   = has_line(hum_q) ? 2'b01 : (cnt_q == 4'd9) ? 2'b11 : win_q;
            end
            COMP_TURN: begin
                fb_d    = !(one_hot(comp_move) && (comp_move & occ) == 9'd0);
                comp_d  = comp_q | (fb_d ? low_free : comp_move);
                cnt_d   = cnt_q + 4'd1;
                state_d = C_CHECK;
            end
            C_CHECK: begin
                state_d = (has_line(comp_q) || cnt_q == 4'd9) ? DONE : HUMAN_TURN;
                win_d   = has_line(comp_q) ? 2'b10 : (cnt_q == 4'd9) ? 2'b11 : win_q;
            end
            DONE: ;
            default: state_d = IDLE;
        endcase
        if (start) begin
            state_d = HUMAN_TURN;
            comp_d  = 9'd0;
            hum_d   = 9'd0;
            cnt_d   = 4'd0;
            win_d   = 2'b00;
            ill_d   = 1'b0;
            fb_d    = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            comp_q  <= 9'd0;
            hum_q   <= 9'd0;
            cnt_q   <= 4'd0;
            win_q   <= 2'b00;
            ill_q   <= 1'b0;
            fb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            comp_q  <= comp_d;
            hum_q   <= hum_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            ill_q   <= ill_d;
            fb_q    <= fb_d;
        end
    end
    assign computer    = comp_q;
    assign human       = hum_q;
    assign move_count  = cnt_q;
    assign winner      = win_q;
    assign illegal     = ill_q;
    assign fallback    = fb_q;
    assign human_ready = state_q == HUMAN_TURN;
    assign game_over   = state_q == DONE;
endmodule

// File: tb/tb_board_controller.sv
// tb_board_controller: directed cycle-by-cycle vectors for board_controller.
// Outputs packed as {computer, human, move_count, winner, ready, illegal, fallback, game_over}.
module tb_board_controller;
    logic       clk = 1'b0, reset = 1'b1, start = 1'b0, human_valid = 1'b0;
    logic [8:0] human_move = 9'd0, comp_move = 9'd0;
    logic [8:0] computer, human;
    logic       human_ready, illegal, fallback, game_over;
    logic [1:0] winner;
    logic [3:0] move_count;
    int checks = 0, errors = 0;

    typedef struct {
        logic       st;
        logic       hv;
        logic [8:0] hm;
        logic [8:0] cm;
        logic [27:0] exp;
    } vec_t;
    vec_t vecs[$];

    board_controller dut (
        .clk(clk), .reset(reset), .start(start), .human_move(human_move),
        .human_valid(human_valid), .comp_move(comp_move), .computer(computer),
        .human(human), .human_ready(human_ready), .illegal(illegal),
        .fallback(fallback), .game_over(game_over), .winner(winner),
        .move_count(move_count)
    );

    always #5 clk = ~clk;

    function automatic logic [27:0] outs();
        return {computer, human, move_count, winner, human_ready, illegal, fallback, game_over};
    endfunction

    task automatic add(input logic st, input logic hv, input logic [8:0] hm, input logic [8:0] cm,
                       input logic [8:0] c, input logic [8:0] h, input logic [3:0] n,
                       input logic [1:0] w, input logic [3:0] flags);
        vec_t v;
        v.st = st; v.hv = hv; v.hm = hm; v.cm = cm; v.exp = {c, h, n, w, flags};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [27:0] got, input logic [27:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic step(input logic st, input logic hv, input logic [8:0] hm, input logic [8:0] cm);
        start = st; human_valid = hv; human_move = hm; comp_move = cm;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // flags = {ready, illegal, fallback, game_over}
        // Game A: basic turn, illegal moves, two fallbacks, human diagonal win
        add(1, 0, 9'h000, 9'h000, 9'h000, 9'h000, 0, 2'b00, 4'b1000);
        add(0, 1, 9'h010, 9'h000, 9'h000, 9'h010, 1, 2'b00, 4'b0000);
        add(0, 0, 9'h000, 9'h000, 9'h000, 9'h010, 1, 2'b00, 4'b0000);
        add(0, 0, 9'h000, 9'h008, 9'h008, 9'h010, 2, 2'b00, 4'b0000);
        add(0, 0, 9'h000, 9'h000, 9'h008, 9'h010, 2, 2'b00, 4'b1000);
        add(0, 1, 9'h010, 9'h000, 9'h008, 9'h010, 2, 2'b00, 4'b1100);
        add(0, 1, 9'h003, 9'h000, 9'h008, 9'h010, 2, 2'b00, 4'b1100);
        add(0, 1, 9'h000, 9'h000, 9'h008, 9'h010, 2, 2'b00, 4'b1100);
        add(0, 0, 9'h000, 9'h000, 9'h008, 9'h010, 2, 2'b00, 4'b1000);
        add(0, 1, 9'h001, 9'h000, 9'h008, 9'h011, 3, 2'b00, 4'b0000);
        add(0, 0, 9'h000, 9'h000, 9'h008, 9'h011, 3, 2'b00, 4'b0000);
        add(0, 0, 9'h000, 9'h000, 9'h00A, 9'h011, 4, 2'b00, 4'b0010);
        add(0, 0, 9'h000, 9'h000, 9'h00A, 9'h011, 4, 2'b00, 4'b1000);
        add(0, 1, 9'h020, 9'h000, 9'h00A, 9'h031, 5, 2'b00, 4'b0000);
        add(0, 0, 9'h000, 9'h000, 9'h00A, 9'h031, 5, 2'b00, 4'b0000);
        add(0, 0, 9'h000, 9'h010, 9'h00E, 9'h031, 6, 2'b00, 4'b0010);
        add(0, 0, 9'h000, 9'h000, 9'h00E, 9'h031, 6, 2'b00, 4'b1000);
        add(0, 1, 9'h100, 9'h000, 9'h00E, 9'h131, 7, 2'b00, 4'b0000);
        add(0, 0, 9'h000, 9'h000, 9'h00E, 9'h131, 7, 2'b01, 4'b0001);
        add(0, 1, 9'h040, 9'h000, 9'h00E, 9'h131, 7, 2'b01, 4'b0001);
        add(0, 1, 9'h080, 9'h040, 9'h00E, 9'h131, 7, 2'b01, 4'b0001);
        // Draw game; start in DONE wins over a simultaneous human_valid
        add(1, 1, 9'h010, 9'h000, 9'h000, 9'h000, 0, 2'b00, 4'b1000);
        add(0, 1, 9'h100, 9'h000, 9'h000, 9'h100, 1, 2'b00, 4'b0000);
        add(0, 0, 9'h000, 9'h000, 9'h000, 9'h100, 1, 2'b00, 4'b0000);
        add(0, 0, 9'h000, 9'h010, 9'h010, 9'h100, 2, 2'b00, 4'b0000);
        add(0, 0, 9'h000, 9'h000, 9'h010, 9'h100, 2, 2'b00, 4'b1000);
        add(0, 1, 9'h040, 9'h000, 9'h010, 9'h140, 3, 2'b00, 4'b0000);
        add(0, 0, 9'h000, 9'h000, 9'h010, 9'h140, 3, 2'b00, 4'b0000);
        add(0, 0, 9'h000, 9'h080, 9'h090, 9'h140, 4, 2'b00, 4'b0000);
        add(0, 0, 9'h000, 9'h000, 9'h090, 9'h140, 4, 2'b00, 4'b1000);
        add(0, 1, 9'h002, 9'h000, 9'h090, 9'h142, 5, 2'b00, 4'b0000);
        add(0, 0, 9'h000, 9'h000, 9'h090, 9'h142, 5, 2'b00, 4'b0000);
        add(0, 0, 9'h000, 9'h008, 9'h098, 9'h142, 6, 2'b00, 4'b0000);
        add(0, 0, 9'h000, 9'h000, 9'h098, 9'h142, 6, 2'b00, 4'b1000);
        add(0, 1, 9'h020, 9'h000, 9'h098, 9'h162, 7, 2'b00, 4'b0000);
        add(0, 0, 9'h000, 9'h000, 9'h098, 9'h162, 7, 2'b00, 4'b0000);
        add(0, 0, 9'h000, 9'h004, 9'h09C, 9'h162, 8, 2'b00, 4'b0000);
        add(0, 0, 9'h000, 9'h000, 9'h09C, 9'h162, 8, 2'b00, 4'b1000);
        add(0, 1, 9'h001, 9'h000, 9'h09C, 9'h163, 9, 2'b00, 4'b0000);
        add(0, 0, 9'h000, 9'h000, 9'h09C, 9'h163, 9, 2'b11, 4'b0001);
        // Computer wins on the {6,4,2} diagonal
        add(1, 0, 9'h000, 9'h000, 9'h000, 9'h000, 0, 2'b00, 4'b1000);
        add(0, 1, 9'h100, 9'h000, 9'h000, 9'h100, 1, 2'b00, 4'b0000);
        add(0, 0, 9'h000, 9'h000, 9'h000, 9'h100, 1, 2'b00, 4'b0000);
        add(0, 0, 9'h000, 9'h010, 9'h010, 9'h100, 2, 2'b00, 4'b0000);
        add(0, 0, 9'h000, 9'h000, 9'h010, 9'h100, 2, 2'b00, 4'b1000);
        add(0, 1, 9'h080, 9'h000, 9'h010, 9'h180, 3, 2'b00, 4'b0000);
        add(0, 0, 9'h000, 9'h000, 9'h010, 9'h180, 3, 2'b00, 4'b0000);
        add(0, 0, 9'h000, 9'h004, 9'h014, 9'h180, 4, 2'b00, 4'b0000);
        add(0, 0, 9'h000, 9'h000, 9'h014, 9'h180, 4, 2'b00, 4'b1000);
        add(0, 1, 9'h001, 9'h000, 9'h014, 9'h181, 5, 2'b00, 4'b0000);
        add(0, 0, 9'h000, 9'h000, 9'h014, 9'h181, 5, 2'b00, 4'b0000);
        add(0, 0, 9'h000, 9'h040, 9'h054, 9'h181, 6, 2'b00, 4'b0000);
        add(0, 0, 9'h000, 9'h000, 9'h054, 9'h181, 6, 2'b10, 4'b0001);

        #2;
        check("reset_state", outs(), 28'h0);
        #1 reset = 1'b0;
        step(0, 1, 9'h010, 9'h000);
        check("idle_ignores_move", outs(), 28'h0);
        foreach (vecs[i]) begin
            step(vecs[i].st, vecs[i].hv, vecs[i].hm, vecs[i].cm);
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end
        // Async reset in the middle of COMP_TURN
        step(1, 0, 9'h000, 9'h000);
        check("restart_from_done", outs(), {9'h000, 9'h000, 4'd0, 2'b00, 4'b1000});
        step(0, 1, 9'h010, 9'h000);
        step(0, 0, 9'h000, 9'h000);
        check("in_comp_turn", outs(), {9'h000, 9'h010, 4'd1, 2'b00, 4'b0000});
        #2 reset = 1'b1;
        #1;
        check("async_reset_mid_game", outs(), 28'h0);
        #1 reset = 1'b0;
        step(0, 0, 9'h000, 9'h008);
        check("abandoned_game", outs(), 28'h0);
        step(0, 1, 9'h020, 9'h000);
        check("needs_start", outs(), 28'h0);
        step(1, 0, 9'h000, 9'h000);
        check("start_after_reset", outs(), {9'h000, 9'h000, 4'd0, 2'b00, 4'b1000});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
